// File: rtl/nx_pkg.sv
// Shared types and constants for the no-execute fault handler: FSM states,
// the NX trap cause code and the captured trap-request record.
package nx_pkg;

    localparam logic [7:0] NX_CAUSE    = 8'h0C;
    localparam int         NX_PC_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REPORT = 2'b01,
        ST_FLUSH  = 2'b10
    } nx_state_e;

    // The pc field is sized for the widest supported VA; narrower VAs are zero-extended.
    typedef struct packed {
        logic [NX_PC_MAX_W-1:0] pc;
        logic [1:0]             priv;
        logic [7:0]             cause;
    } nx_trap_req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides a
// same-cycle increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_nxt_s;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = {WIDTH{1'b0}};
        end else if (inc && (count_r != {WIDTH{1'b1}})) begin
            count_nxt_s = count_r + WIDTH'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/nx_fault_handler.sv
// No-execute fault handler: captures one NX fault at a time, reports it to
// the trap unit, then requests a front-end flush before accepting another.
module nx_fault_handler
    import nx_pkg::*;
#(
    parameter int VA_WIDTH  = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 fault_i,
    input  logic [VA_WIDTH-1:0]  fault_pc_i,
    input  logic [1:0]           fault_priv_i,
    output logic                 trap_valid_o,
    input  logic                 trap_ready_i,
    output logic [VA_WIDTH-1:0]  trap_pc_o,
    output logic [7:0]           trap_cause_o,
    output logic [1:0]           trap_priv_o,
    output logic                 flush_req_o,
    input  logic                 flush_ack_i,
    output logic                 fetch_stall_o,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] fault_count_o,
    output logic                 fault_dropped_o
);

    nx_state_e    state_r;
    nx_state_e    state_nxt_s;
    nx_trap_req_t trap_req_r;
    logic         accept_s;
    logic         drop_s;
    logic         dropped_r;

    // Only an idle handler takes a fault; anything else (including the flush-ack cycle) is dropped.
    assign accept_s = fault_i && (state_r == ST_IDLE);
    assign drop_s   = fault_i && (state_r != ST_IDLE);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fault_i) begin
                    state_nxt_s = ST_REPORT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REPORT: begin
                if (trap_ready_i) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            ST_FLUSH: begin
                if (flush_ack_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state only, so fault_i never reaches an output combinationally.
    always_comb begin
        trap_valid_o  = 1'b0;
        flush_req_o   = 1'b0;
        fetch_stall_o = 1'b0;
        case (state_r)
            ST_IDLE: begin
                trap_valid_o  = 1'b0;
                flush_req_o   = 1'b0;
                fetch_stall_o = 1'b0;
            end
            ST_REPORT: begin
                trap_valid_o  = 1'b1;
                flush_req_o   = 1'b0;
                fetch_stall_o = 1'b1;
            end
            ST_FLUSH: begin
                trap_valid_o  = 1'b0;
                flush_req_o   = 1'b1;
                fetch_stall_o = 1'b1;
            end
            default: begin
                trap_valid_o  = 1'b0;
                flush_req_o   = 1'b0;
                fetch_stall_o = 1'b0;
            end
        endcase
    end

    // Capture of the faulting access; held until the next accepted fault.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_req_r <= '0;
        end else if (accept_s) begin
            trap_req_r.pc    <= NX_PC_MAX_W'(fault_pc_i);
            trap_req_r.priv  <= fault_priv_i;
            trap_req_r.cause <= NX_CAUSE;
        end else begin
            trap_req_r <= trap_req_r;
        end
    end

    // Sticky drop flag; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_r <= 1'b0;
        end else if (clr_i) begin
            dropped_r <= 1'b0;
        end else if (drop_s) begin
            dropped_r <= 1'b1;
        end else begin
            dropped_r <= dropped_r;
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_fault_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .inc   (accept_s),
        .clr   (clr_i),
        .count (fault_count_o)
    );

    assign trap_pc_o       = trap_req_r.pc[VA_WIDTH-1:0];
    assign trap_priv_o     = trap_req_r.priv;
    assign trap_cause_o    = trap_valid_o ? trap_req_r.cause : 8'h00;
    assign fault_dropped_o = dropped_r;

endmodule

// File: tb/tb_nx_fault_handler.sv
// Directed bench for nx_fault_handler: a flag-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_nx_fault_handler;

    localparam int VAW  = 64;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           fault = 1'b0;
    logic [VAW-1:0] fault_pc = '0;
    logic [1:0]     fault_priv = 2'b00;
    logic           ready = 1'b0;
    logic           ack = 1'b0;
    logic           clr = 1'b0;

    logic           trap_valid;
    logic [VAW-1:0] trap_pc;
    logic [7:0]     trap_cause;
    logic [1:0]     trap_priv;
    logic           flush_req;
    logic           fetch_stall;
    logic [CW-1:0]  fault_count;
    logic           fault_dropped;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    nx_fault_handler #(
        .VA_WIDTH  (VAW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .fault_i         (fault),
        .fault_pc_i      (fault_pc),
        .fault_priv_i    (fault_priv),
        .trap_valid_o    (trap_valid),
        .trap_ready_i    (ready),
        .trap_pc_o       (trap_pc),
        .trap_cause_o    (trap_cause),
        .trap_priv_o     (trap_priv),
        .flush_req_o     (flush_req),
        .flush_ack_i     (ack),
        .fetch_stall_o   (fetch_stall),
        .clr_i           (clr),
        .fault_count_o   (fault_count),
        .fault_dropped_o (fault_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fault is either waiting for the trap unit or waiting for the flush.
    bit             m_reporting = 1'b0;
    bit             m_flushing = 1'b0;
    bit             m_busy;
    bit             m_dropped = 1'b0;
    logic [VAW-1:0] m_pc = '0;
    logic [1:0]     m_priv = 2'b00;
    int             m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reporting = 1'b0; m_flushing = 1'b0; m_dropped = 1'b0;
            m_pc = '0; m_priv = 2'b00; m_count = 0;
        end else begin
            m_busy = m_reporting || m_flushing;
            if (fault && !m_busy) begin
                m_pc = fault_pc;
                m_priv = fault_priv;
            end
            if (clr) begin
                m_count = 0;
                m_dropped = 1'b0;
            end else begin
                if (fault && !m_busy) m_count = (m_count >= CMAX) ? CMAX : m_count + 1;
                if (fault && m_busy) m_dropped = 1'b1;
            end
            if (m_reporting) begin
                if (ready) begin m_reporting = 1'b0; m_flushing = 1'b1; end
            end else if (m_flushing) begin
                if (ack) m_flushing = 1'b0;
            end else if (fault) begin
                m_reporting = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_trap_valid", trap_valid, m_reporting);
            chk("m_flush_req", flush_req, m_flushing);
            chk("m_fetch_stall", fetch_stall, m_reporting || m_flushing);
            chk("m_trap_cause", trap_cause, m_reporting ? 64'h0C : 64'h0);
            chk("m_trap_pc", trap_pc, m_pc);
            chk("m_trap_priv", trap_priv, m_priv);
            chk("m_fault_count", fault_count, m_count);
            chk("m_fault_dropped", fault_dropped, m_dropped);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check_en = 1'b1;
        chk("rst_valid", trap_valid, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_count", fault_count, 0);
        chk("rst_pc", trap_pc, 0);
        chk("rst_cause", trap_cause, 0);
        rst_n = 1'b1;
        tick();

        // Single fault: valid for three cycles, ready on the third.
        fault = 1'b1; fault_pc = 64'h4000_1000; fault_priv = 2'b00;
        tick(); fault = 1'b0;
        chk("sf_valid_first", trap_valid, 1);
        chk("sf_pc", trap_pc, 64'h4000_1000);
        chk("sf_cause", trap_cause, 64'h0C);
        tick(); tick();
        ready = 1'b1;
        chk("sf_valid_third", trap_valid, 1);
        tick(); ready = 1'b0;
        chk("sf_valid_drop", trap_valid, 0);
        chk("sf_flush", flush_req, 1);
        chk("sf_count", fault_count, 1);
        tick();
        chk("sf_flush_hold", flush_req, 1);
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("sf_flush_done", flush_req, 0);
        chk("sf_stall_done", fetch_stall, 0);

        // Back-pressure with a stray ack and a dropped fault during REPORT.
        fault = 1'b1; fault_pc = 64'h1234_5678_9ABC_DEF0; fault_priv = 2'b11;
        tick(); fault = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) ack = 1'b1;
            if (i == 4) begin fault = 1'b1; fault_pc = 64'hDEAD_0000; end
            tick();
            ack = 1'b0; fault = 1'b0;
            chk("bp_pc", trap_pc, 64'h1234_5678_9ABC_DEF0);
            chk("bp_cause", trap_cause, 64'h0C);
            chk("bp_stall", fetch_stall, 1);
        end
        chk("drop_flag", fault_dropped, 1);
        chk("drop_count", fault_count, 2);
        chk("drop_priv", trap_priv, 2'b11);
        ready = 1'b1;
        tick(); ready = 1'b0;
        chk("bp_flush", flush_req, 1);

        // Clear during FLUSH, then a fault on the ack cycle is dropped.
        clr = 1'b1;
        tick(); clr = 1'b0;
        chk("clr_count", fault_count, 0);
        chk("clr_dropped", fault_dropped, 0);
        chk("clr_fsm_kept", flush_req, 1);
        ack = 1'b1; fault = 1'b1; fault_pc = 64'h5555_0000;
        tick(); ack = 1'b0; fault = 1'b0;
        chk("ackdrop_stall", fetch_stall, 0);
        chk("ackdrop_flag", fault_dropped, 1);
        chk("ackdrop_pc", trap_pc, 64'h1234_5678_9ABC_DEF0);

        // Saturation: 17 accepted faults on a 4-bit counter.
        clr = 1'b1;
        tick(); clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            fault = 1'b1; fault_pc = 64'(k) << 8;
            tick(); fault = 1'b0; ready = 1'b1;
            tick(); ready = 1'b0; ack = 1'b1;
            tick(); ack = 1'b0;
        end
        chk("sat_count", fault_count, 15);
        chk("sat_pc", trap_pc, 64'h1000);
        clr = 1'b1; fault = 1'b1; fault_pc = 64'h7777_0000; fault_priv = 2'b01;
        tick(); clr = 1'b0; fault = 1'b0;
        chk("clrinc_count", fault_count, 0);
        chk("clrinc_valid", trap_valid, 1);
        chk("clrinc_pc", trap_pc, 64'h7777_0000);
        ready = 1'b1;
        tick(); ready = 1'b0;
        chk("pre_rst_flush", flush_req, 1);

        // Reset in the middle of FLUSH, then a fresh fault.
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", flush_req, 0);
        chk("mid_rst_stall", fetch_stall, 0);
        chk("mid_rst_valid", trap_valid, 0);
        chk("mid_rst_pc", trap_pc, 0);
        chk("mid_rst_priv", trap_priv, 0);
        tick();
        rst_n = 1'b1;
        tick();
        fault = 1'b1; fault_pc = 64'hABCD_0000; fault_priv = 2'b10;
        tick(); fault = 1'b0;
        chk("post_rst_valid", trap_valid, 1);
        chk("post_rst_pc", trap_pc, 64'hABCD_0000);
        ready = 1'b1;
        tick(); ready = 1'b0; ack = 1'b1;
        tick(); ack = 1'b0;
        chk("post_rst_count", fault_count, 1);
        chk("post_rst_stall", fetch_stall, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nx_fault_handler.md
NX_FAULT_HANDLER -- requirements
Module: nx_fault_handler

Interface
REQ-001 SHALL have parameter VA_WIDTH, default 64, the fault/trap address width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, the fault counter width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have port fault_i  in  1  NX fault pulse from the no-execute checker.
REQ-007 SHALL have port fault_pc_i  in  VA_WIDTH  fetch PC of the faulting access.
REQ-008 SHALL have port fault_priv_i  in  2  privilege level at fault.
REQ-009 SHALL have port trap_valid_o  out  1  trap request to the trap unit.
REQ-010 SHALL have port trap_ready_i  in  1  trap unit accepts the request.
REQ-011 SHALL have port trap_pc_o  out  VA_WIDTH  captured faulting PC.
REQ-012 SHALL have port trap_cause_o  out  8  cause code, constant NX_CAUSE (8'h0C) while valid, else 0.
REQ-013 SHALL have port trap_priv_o  out  2  captured privilege.
REQ-014 SHALL have port flush_req_o  out  1  request front-end flush.
REQ-015 SHALL have port flush_ack_i  in  1  flush complete.
REQ-016 SHALL have port fetch_stall_o  out  1  stall fetch while a fault is in flight.
REQ-017 SHALL have port clr_i  in  1  synchronous clear of counter and sticky flag.
REQ-018 SHALL have port fault_count_o  out  CNT_WIDTH  accepted-fault count.
REQ-019 SHALL have port fault_dropped_o  out  1  sticky: a fault arrived while busy.

Function
REQ-020 SHALL implement FSM states IDLE, REPORT, FLUSH.
REQ-021 In IDLE, fault_i=1 SHALL capture fault_pc_i/fault_priv_i and move to REPORT next cycle; trap_valid_o rises one cycle after fault_i.
REQ-022 In REPORT, trap_valid_o SHALL be 1 with trap_pc_o/trap_priv_o/trap_cause_o stable until trap_ready_i=1.
REQ-023 On trap_valid_o & trap_ready_i, the FSM SHALL move to FLUSH; trap_valid_o drops next cycle.
REQ-024 In FLUSH, flush_req_o SHALL be 1; flush_ack_i=1 moves to IDLE next cycle; flush_ack_i outside FLUSH is ignored.
REQ-025 fetch_stall_o SHALL equal (state != IDLE), registered-state based, no combinational path from fault_i.
REQ-026 fault_i while state != IDLE (including the FLUSH->IDLE ack cycle) SHALL NOT be captured and SHALL set fault_dropped_o.
REQ-027 fault_count_o SHALL increment by 1 per accepted fault and saturate at all-ones.
REQ-028 clr_i SHALL zero fault_count_o and fault_dropped_o next cycle, overriding a same-cycle increment or drop; the FSM and capture are unaffected.
REQ-029 trap_pc_o/trap_priv_o SHALL hold the last captured values outside REPORT.

Reset
REQ-030 Reset SHALL force state IDLE; trap_valid_o, flush_req_o, fetch_stall_o, fault_dropped_o = 0; fault_count_o, trap_pc_o, trap_priv_o = 0; trap_cause_o = 0.
REQ-031 Reset asserted mid-operation (REPORT or FLUSH) SHALL abandon the fault immediately with no trap or flush completion expected.

Structure
REQ-032 Shared package nx_pkg SHALL hold the FSM state enum, NX_CAUSE, and the trap-request struct (pc, priv, cause).
REQ-033 A sub-module sat_counter (parameter WIDTH, inc, clr) SHALL implement the saturating counter; all other logic stays in nx_fault_handler.

Verification
REQ-034 Single fault: fault_i at cycle 5 with PC 0x4000_1000 and priv 2'b00; trap_ready_i=1 at cycle 8 -> trap_valid_o high cycles 6-8, flush_req_o from cycle 9 until ack, count=1.
REQ-035 Back-pressure: trap_ready_i low for 10 cycles -> trap_pc_o/trap_cause_o (0x0C) stable and fetch_stall_o=1 throughout.
REQ-036 Busy drop: second fault_i during REPORT with PC 0xDEAD_0000 -> trap_pc_o unchanged, fault_dropped_o=1, count unchanged.
REQ-037 Saturation/clear: CNT_WIDTH=4, 17 accepted faults -> count=15, then clr_i asserted together with an accepted fault -> count=0, FSM in REPORT.
REQ-038 Reset mid-FLUSH: rst_ni low while flush_req_o=1 -> all outputs 0 immediately; a new fault after release is handled normally.
